// File: rtl/turbo_pkg.sv
// Shared constants for the turbo RX packer: PB word counts, pb_size codes, FSM states, CRC-32 constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package turbo_pkg;

  // Words per PHY block, 32-bit words
  localparam int PB_WORDS_16  = 4;
  localparam int PB_WORDS_136 = 34;
  localparam int PB_WORDS_520 = 130;

  // pb_size encodings; 2'b11 aliases PB520
  localparam logic [1:0] PB_SIZE_16  = 2'b00;
  localparam logic [1:0] PB_SIZE_136 = 2'b01;
  localparam logic [1:0] PB_SIZE_520 = 2'b10;

  // FSM states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // CRC-32, MSB-first per byte, no final XOR
  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  // Advance a CRC-32 over one byte, bit 7 first
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/turbo_pack_fifo.sv
// Synchronous FIFO (data + last) buffering packed words toward the master port.
// Latency: a push is visible on dout/~empty the cycle after it is written.
// Backpressure: push while full is accepted only when a pop happens in the same cycle; otherwise it is discarded.
module turbo_pack_fifo
  import turbo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit: equal -> empty, only the wrap bit differs -> full
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot being written, so push is honoured even when full
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Storage array; no reset needed since empty gates all reads
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer update
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/turbo_rx_pack.sv
// Packs 2-bit x4 de-interleaver beats into 32-bit words, FIFO-buffers them, frames each PB with m_last/done.
// Latency: word pushed on its 4th beat is on m_vld the next cycle at the earliest.
// Backpressure: upstream never stalls; FIFO absorbs m_rdy stalls, overflow drops the word and sets sticky ovf.
// Optional TURBO_PACK_CRC_EN: builds a CRC-32 over all PB bytes on crc_out; otherwise crc_out is 0.
module turbo_rx_pack
  import turbo_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [1:0]  pb_size,
  input  logic [1:0]  rdata0,
  input  logic [1:0]  rdata1,
  input  logic [1:0]  rdata2,
  input  logic [1:0]  rdata3,
  input  logic        din_vld,
  output logic [31:0] m_data,
  output logic        m_vld,
  input  logic        m_rdy,
  output logic        m_last,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [31:0] crc_out
);

  logic [1:0]       state;
  logic [1:0]       byte_cnt;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] last_idx;
  logic [23:0]      acc;
  logic             ovf_q;

  logic [7:0]       byte_in;
  logic             start_ok;
  logic             beat;
  logic             word_done;
  logic             is_last;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             drop;
  logic [32:0]      fifo_din;
  logic [32:0]      fifo_dout;

  assign byte_in   = {rdata3, rdata2, rdata1, rdata0};
  assign start_ok  = start & (state == ST_IDLE);
  assign beat      = din_vld & (state == ST_COLLECT);
  assign word_done = beat & (byte_cnt == 2'd3);
  assign is_last   = word_done & (word_cnt == last_idx);
  assign fifo_din  = {is_last, byte_in, acc};
  assign pop       = m_vld & m_rdy;
  assign drop      = word_done & fifo_full & ~pop;

  assign m_vld  = ~fifo_empty;
  assign m_data = fifo_dout[31:0];
  assign m_last = fifo_dout[32];
  assign busy   = (state == ST_COLLECT) | (state == ST_DRAIN);
  assign done   = (state == ST_DONE);
  assign ovf    = ovf_q;

  turbo_pack_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (word_done),
    .din   (fifo_din),
    .full  (fifo_full),
    .pop   (pop),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // PB sequencing; DRAIN exits on empty so a dropped final word still terminates the PB
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start)      state <= ST_COLLECT;
        ST_COLLECT: if (is_last)    state <= ST_DRAIN;
        ST_DRAIN:   if (fifo_empty) state <= ST_DONE;
        default:                    state <= ST_IDLE;
      endcase
    end
  end

  // Byte/word assembly and counters; word_cnt advances even when the word is dropped
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      byte_cnt <= '0;
      word_cnt <= '0;
      last_idx <= '0;
      acc      <= '0;
    end else if (start_ok) begin
      byte_cnt <= '0;
      word_cnt <= '0;
      case (pb_size)
        PB_SIZE_16:  last_idx <= CNT_W'(PB_WORDS_16 - 1);
        PB_SIZE_136: last_idx <= CNT_W'(PB_WORDS_136 - 1);
        default:     last_idx <= CNT_W'(PB_WORDS_520 - 1);
      endcase
    end else if (beat) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    acc[7:0]   <= byte_in;
        2'd1:    acc[15:8]  <= byte_in;
        2'd2:    acc[23:16] <= byte_in;
        default: word_cnt   <= word_cnt + 1'b1;
      endcase
    end
  end

  // Sticky overflow, cleared only by an accepted start
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)        ovf_q <= 1'b0;
    else if (start_ok) ovf_q <= 1'b0;
    else if (drop)     ovf_q <= 1'b1;
  end

`ifdef TURBO_PACK_CRC_EN
  logic [31:0] crc_q;

  // Running CRC over every collected byte, including bytes of dropped words
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)        crc_q <= 32'h0;
    else if (start_ok) crc_q <= CRC32_INIT;
    else if (beat)     crc_q <= crc32_byte(crc_q, byte_in);
  end

  assign crc_out = crc_q;
`else
  assign crc_out = 32'h0;
`endif

endmodule

// File: tb/tb_turbo_rx_pack.sv
// Randomized bench for turbo_rx_pack against a queue/occupancy reference model.
// Latency: model tracks one transfer per clock, sampled on the falling edge.
// Backpressure: bench drives m_rdy patterns (always, 1-of-2, never) to exercise stall and overflow.
module tb_turbo_rx_pack;

  localparam int DEPTH = 8;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [1:0]  pb_size;
  logic [1:0]  rdata0, rdata1, rdata2, rdata3;
  logic        din_vld;
  logic [31:0] m_data;
  logic        m_vld;
  logic        m_rdy;
  logic        m_last;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [31:0] crc_out;

  always #5 clk = ~clk;

  turbo_rx_pack #(.FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .pb_size(pb_size),
    .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3),
    .din_vld(din_vld), .m_data(m_data), .m_vld(m_vld), .m_rdy(m_rdy),
    .m_last(m_last), .busy(busy), .done(done), .ovf(ovf), .crc_out(crc_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 idle, 1 collecting, 2 draining, 3 done pulse
  int          mph;
  int          occ;
  int          total;
  bit          exp_ovf;
  logic [7:0]  pb_bytes[$];
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  bit          held_v;
  logic [32:0] held;
  int          vld_err, done_err, busy_err, ovf_err, stall_err;

  logic [32:0] t1_words [4] = '{{1'b0, 32'h03020100}, {1'b0, 32'h07060504},
                                {1'b0, 32'h0B0A0908}, {1'b1, 32'h0F0E0D0C}};

  function automatic int words_for(input logic [1:0] sz);
    if (sz == 2'b00) return 4;
    if (sz == 2'b01) return 34;
    return 130;
  endfunction

  function automatic logic [31:0] crc_ref();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (pb_bytes[i]) begin
      c = c ^ {pb_bytes[i], 24'h0};
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  function automatic int count_last();
    int n;
    n = 0;
    foreach (got_q[i]) if (got_q[i][32]) n++;
    return n;
  endfunction

  function automatic bit data_ok();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    mph = 0; occ = 0; total = 0; exp_ovf = 1'b0; held_v = 1'b0;
    pb_bytes.delete(); exp_q.delete(); got_q.delete();
  endtask

  task automatic clear_tallies();
    vld_err = 0; done_err = 0; busy_err = 0; ovf_err = 0; stall_err = 0;
    got_q.delete(); exp_q.delete();
  endtask

  // One clock: drive inputs, capture DUT handshake, advance model, tally per-cycle output agreement
  task automatic cycle(input bit v, input logic [7:0] b, input bit r, input bit st, input logic [1:0] sz);
    bit pop, push, lst;
    int nph, n;
    logic [31:0] w;
    din_vld = v; {rdata3, rdata2, rdata1, rdata0} = b; m_rdy = r; start = st; pb_size = sz;
    if (m_vld && r) got_q.push_back({m_last, m_data});
    if (held_v && m_vld && ({m_last, m_data} !== held)) stall_err++;
    held_v = m_vld && !r;
    held   = {m_last, m_data};
    pop = r && (occ > 0);
    push = 1'b0;
    nph = mph;
    case (mph)
      0: if (st) begin
           nph = 1; total = 4 * words_for(sz); pb_bytes.delete(); exp_ovf = 1'b0;
         end
      1: if (v) begin
           pb_bytes.push_back(b);
           n = pb_bytes.size();
           if (n % 4 == 0) begin
             w = {pb_bytes[n-1], pb_bytes[n-2], pb_bytes[n-3], pb_bytes[n-4]};
             lst = (n == total);
             if (occ < DEPTH || pop) begin
               exp_q.push_back({lst, w});
               push = 1'b1;
             end else begin
               exp_ovf = 1'b1;
             end
             if (lst) nph = 2;
           end
         end
      2: if (occ == 0) nph = 3;
      default: nph = 0;
    endcase
    occ = occ + int'(push) - int'(pop);
    mph = nph;
    @(posedge clk);
    @(negedge clk);
    if (m_vld !== (occ > 0)) vld_err++;
    if (done !== (mph == 3)) done_err++;
    if (busy !== (mph == 1 || mph == 2)) busy_err++;
    if (ovf !== exp_ovf) ovf_err++;
  endtask

  // Idle the lanes until the model returns to idle; rmode 0: m_rdy=1, 1: m_rdy 1-of-2
  task automatic finish_pb(input int rmode, output bit to);
    int k;
    k = 0;
    while (mph != 0 && k < 3000) begin
      cycle(1'b0, 8'h00, (rmode == 0) ? 1'b1 : 1'(k % 2), 1'b0, 2'b00);
      k++;
    end
    to = (mph != 0);
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 0; pb_size = 0; din_vld = 0; m_rdy = 0;
    rdata0 = 0; rdata1 = 0; rdata2 = 0; rdata3 = 0;
    model_reset();
    #12;
    n_cmp++; if (m_vld !== 1'b0)   begin n_bad++; $display("FAIL reset_m_vld: got %b want 0", m_vld); end
    n_cmp++; if (m_last !== 1'b0)  begin n_bad++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)    begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (ovf !== 1'b0)     begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_cmp++; if (crc_out !== 32'h0) begin n_bad++; $display("FAIL reset_crc: got %h want 0", crc_out); end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pb16_basic();
    bit to;
    clear_tallies();
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 2'b00);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0, 2'b00);
    finish_pb(0, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL pb16_timeout: phase %0d want 0", mph); end
    n_cmp++;
    if (got_q.size() != 4) begin
      n_bad++; $display("FAIL pb16_count: got %0d words want 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (got_q[i] !== t1_words[i]) begin
          n_bad++; $display("FAIL pb16_word%0d: got %h want %h", i, got_q[i], t1_words[i]); break;
        end
    end
    n_cmp++;
    if (vld_err + done_err + busy_err + ovf_err + stall_err != 0) begin
      n_bad++; $display("FAIL pb16_cycle: vld %0d done %0d busy %0d ovf %0d stall %0d want all 0",
                        vld_err, done_err, busy_err, ovf_err, stall_err);
    end
  endtask

  task automatic test_pb136_stall();
    bit to;
    int k;
    clear_tallies();
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 2'b01);
    k = 0;
    while (mph == 1 && k < 2000) begin
      cycle(1'($urandom % 2), 8'($urandom), 1'(k % 2), 1'b0, 2'b01);
      k++;
    end
    finish_pb(1, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL pb136_timeout: phase %0d want 0", mph); end
    n_cmp++; if (got_q.size() != 34) begin n_bad++; $display("FAIL pb136_count: got %0d want 34", got_q.size()); end
    n_cmp++; if (!data_ok()) begin n_bad++; $display("FAIL pb136_data: got %0d words, model %0d, contents differ", got_q.size(), exp_q.size()); end
    n_cmp++;
    if (count_last() != 1 || got_q.size() == 0 || got_q[got_q.size()-1][32] !== 1'b1) begin
      n_bad++; $display("FAIL pb136_last: got %0d last flags want 1 on final word", count_last());
    end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL pb136_ovf: got %b want 0", ovf); end
    n_cmp++;
    if (vld_err + done_err + busy_err + ovf_err + stall_err != 0) begin
      n_bad++; $display("FAIL pb136_cycle: vld %0d done %0d busy %0d ovf %0d stall %0d want all 0",
                        vld_err, done_err, busy_err, ovf_err, stall_err);
    end
`ifdef TURBO_PACK_CRC_EN
    n_cmp++; if (crc_out !== crc_ref()) begin n_bad++; $display("FAIL pb136_crc: got %h want %h", crc_out, crc_ref()); end
`endif
  endtask

  task automatic test_pb520_overflow();
    bit to;
    int k;
    clear_tallies();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 2'b10);
    k = 0;
    while (mph == 1 && k < 1000) begin
      cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 2'b10);
      k++;
    end
    n_cmp++;
    if (ovf !== 1'b1 || m_vld !== 1'b1 || got_q.size() != 0) begin
      n_bad++; $display("FAIL pb520_stalled: ovf %b m_vld %b delivered %0d want 1 1 0", ovf, m_vld, got_q.size());
    end
    finish_pb(0, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL pb520_timeout: phase %0d want 0", mph); end
    n_cmp++; if (got_q.size() != 8) begin n_bad++; $display("FAIL pb520_count: got %0d want 8", got_q.size()); end
    n_cmp++; if (!data_ok()) begin n_bad++; $display("FAIL pb520_data: got %0d words, model %0d, contents differ", got_q.size(), exp_q.size()); end
    n_cmp++; if (count_last() != 0) begin n_bad++; $display("FAIL pb520_last: got %0d last flags want 0", count_last()); end
    n_cmp++; if (busy !== 1'b0 || ovf !== 1'b1) begin n_bad++; $display("FAIL pb520_end: busy %b ovf %b want 0 1", busy, ovf); end
    n_cmp++;
    if (vld_err + done_err + busy_err + ovf_err + stall_err != 0) begin
      n_bad++; $display("FAIL pb520_cycle: vld %0d done %0d busy %0d ovf %0d stall %0d want all 0",
                        vld_err, done_err, busy_err, ovf_err, stall_err);
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    int k;
    clear_tallies();
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 2'b01);
    n_cmp++; if (ovf !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL restart_clear: ovf %b busy %b want 0 1", ovf, busy); end
    k = 0;
    while (mph == 1 && k < 2000) begin
      cycle(1'b1, 8'($urandom), 1'(k % 2), k == 20, (k == 20) ? 2'b00 : 2'b01);
      k++;
    end
    finish_pb(1, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL midstart_timeout: phase %0d want 0", mph); end
    n_cmp++; if (got_q.size() != 34) begin n_bad++; $display("FAIL midstart_count: got %0d want 34", got_q.size()); end
    n_cmp++; if (!data_ok()) begin n_bad++; $display("FAIL midstart_data: got %0d words, model %0d, contents differ", got_q.size(), exp_q.size()); end
    n_cmp++;
    if (vld_err + done_err + busy_err + ovf_err + stall_err != 0) begin
      n_bad++; $display("FAIL midstart_cycle: vld %0d done %0d busy %0d ovf %0d stall %0d want all 0",
                        vld_err, done_err, busy_err, ovf_err, stall_err);
    end
    clear_tallies();
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 2'b00);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL next_start: busy %b want 1", busy); end
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 2'b00);
    finish_pb(0, to);
    n_cmp++; if (to || !data_ok() || got_q.size() != 4) begin n_bad++; $display("FAIL next_pb: got %0d words timeout %b want 4 0", got_q.size(), to); end
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_tallies();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 2'b00);
    n_cmp++; if (m_vld !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL prereset: m_vld %b busy %b want 1 1", m_vld, busy); end
    #2 n_rst = 1'b0;
    #1;
    n_cmp++;
    if (m_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: m_vld %b busy %b done %b ovf %b want 0 0 0 0", m_vld, busy, done, ovf);
    end
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    clear_tallies();
    @(negedge clk);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 2'b00);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 2'b00);
    finish_pb(0, to);
    n_cmp++; if (to || got_q.size() != 4) begin n_bad++; $display("FAIL postreset_count: got %0d timeout %b want 4 0", got_q.size(), to); end
    n_cmp++; if (!data_ok() || count_last() != 1) begin n_bad++; $display("FAIL postreset_data: lasts %0d contents differ from model", count_last()); end
    n_cmp++;
    if (vld_err + done_err + busy_err + ovf_err + stall_err != 0) begin
      n_bad++; $display("FAIL postreset_cycle: vld %0d done %0d busy %0d ovf %0d stall %0d want all 0",
                        vld_err, done_err, busy_err, ovf_err, stall_err);
    end
  endtask

  task automatic test_crc();
    bit to;
    logic [31:0] want;
    clear_tallies();
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 2'b00);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'h00, 1'b1, 1'b0, 2'b00);
    finish_pb(0, to);
`ifdef TURBO_PACK_CRC_EN
    want = crc_ref();
`else
    want = 32'h0;
`endif
    n_cmp++; if (to || crc_out !== want) begin n_bad++; $display("FAIL crc_zero16: got %h want %h", crc_out, want); end
    n_cmp++; if (!data_ok()) begin n_bad++; $display("FAIL crc_data: got %0d words, model %0d, contents differ", got_q.size(), exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_pb16_basic();
    test_pb136_stall();
    test_pb520_overflow();
    test_start_ignored();
    test_reset_mid();
    test_crc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
